// File: rtl/sensor_emulator.sv
// Emulated image-sensor parallel port: divided pixel clock plus LV/FV/12-bit data,
// producing one deterministic ramp frame per trigger rising edge.
module sensor_emulator #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 8,
  parameter int unsigned V_ACTIVE = 4,
  parameter int unsigned H_BLANK  = 4,
  parameter int unsigned FV_LEAD  = 2,
  parameter int unsigned FV_TRAIL = 2,
  parameter logic [11:0] SEED     = 12'h000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trigger,
  output logic        pixclk,
  output logic        line_valid,
  output logic        frame_valid,
  output logic [11:0] dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [15:0] LEAD_LAST  = 16'(FV_LEAD - 1);
  localparam logic [15:0] COL_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] ROW_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] HB_LAST    = 16'(H_BLANK - 1);
  localparam logic [15:0] TRAIL_LAST = 16'(FV_TRAIL - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_LINE,
    ST_HBLANK,
    ST_TRAIL
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          pixclk_q, pixclk_d;
  logic          trig_q, trig_d;
  logic          arm_q, arm_d;
  logic          pending_q, pending_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   col_q, col_d;
  logic [15:0]   row_q, row_d;
  logic [11:0]   acc_q, acc_d;
  logic          lv_q, lv_d;
  logic          fv_q, fv_d;
  logic [11:0]   dout_q, dout_d;
  logic          done_q, done_d;
  logic          tick;
  logic          rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      pixclk_q  <= 1'b0;
      trig_q    <= 1'b0;
      arm_q     <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      acc_q     <= '0;
      lv_q      <= 1'b0;
      fv_q      <= 1'b0;
      dout_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pixclk_q  <= pixclk_d;
      trig_q    <= trig_d;
      arm_q     <= arm_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      acc_q     <= acc_d;
      lv_q      <= lv_d;
      fv_q      <= fv_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    acc_d     = acc_q;
    lv_d      = lv_q;
    fv_d      = fv_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    pending_d = pending_q;

    tick     = (div_q == DIV_LAST);
    div_d    = tick ? '0 : div_q + 1'b1;
    // pixclk tracks the next divider value so its fall lands on the tick edge
    pixclk_d = (div_d >= DIV_HALF);

    // arm_q blocks a trigger held high through reset from counting as an edge
    trig_d = trigger;
    arm_d  = arm_q | ~trigger;
    rise   = trigger & ~trig_q & arm_q;

    if (state_q == ST_IDLE && !pending_q && rise) begin
      pending_d = 1'b1;
    end

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            state_d   = ST_LEAD;
            fv_d      = 1'b1;
            pending_d = 1'b0;
            cnt_d     = '0;
            col_d     = '0;
            row_d     = '0;
            acc_d     = SEED;
          end
        end
        ST_LEAD: begin
          if (cnt_q == LEAD_LAST) begin
            state_d = ST_LINE;
            lv_d    = 1'b1;
            dout_d  = acc_q;
            acc_d   = acc_q + 12'd1;
            col_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_LINE: begin
          if (col_q == COL_LAST) begin
            lv_d    = 1'b0;
            dout_d  = '0;
            cnt_d   = '0;
            state_d = (row_q == ROW_LAST) ? ST_TRAIL : ST_HBLANK;
          end else begin
            col_d  = col_q + 16'd1;
            dout_d = acc_q;
            acc_d  = acc_q + 12'd1;
          end
        end
        ST_HBLANK: begin
          if (cnt_q == HB_LAST) begin
            state_d = ST_LINE;
            row_d   = row_q + 16'd1;
            col_d   = '0;
            lv_d    = 1'b1;
            dout_d  = acc_q;
            acc_d   = acc_q + 12'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_TRAIL: begin
          if (cnt_q == TRAIL_LAST) begin
            state_d = ST_IDLE;
            fv_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          lv_d    = 1'b0;
          fv_d    = 1'b0;
          dout_d  = '0;
        end
      endcase
    end
  end

  assign pixclk      = pixclk_q;
  assign line_valid  = lv_q;
  assign frame_valid = fv_q;
  assign dout        = dout_q;
  assign frame_done  = done_q;
  assign busy        = pending_q | (state_q != ST_IDLE);

endmodule
